// File: rtl/mode_sequencer_if.sv
// mode_sequencer_if
//   Groups the button, lock and mode-status signals of mode_sequencer.
//   There is no valid/ready handshake here. Buttons are raw, asynchronous and
//   active-low. lock is synchronous to clk. All status outputs are registered:
//   mode_changed and wrapped are single-cycle pulses that coincide with the
//   first cycle in which the new mode_idx/mode_onehot value is presented.
//
//   Signals:
//     btn_next_n   raw button, active-low, steps the mode forward
//     btn_prev_n   raw button, active-low, steps the mode back
//     lock         high discards press events
//     mode_onehot  one-hot current mode (NUM_MODES bits)
//     mode_idx     binary current mode (IDX_W bits)
//     mode_changed one-cycle pulse on each mode change
//     wrapped      one-cycle pulse when that change wrapped around
//
//   Modports:
//     master  stimulus side (drives buttons and lock)
//     slave   sequencer side (drives the mode outputs)
interface mode_sequencer_if #(
    parameter int NUM_MODES = 4,
    parameter int IDX_W     = 2
);
    logic                 btn_next_n;
    logic                 btn_prev_n;
    logic                 lock;
    logic [NUM_MODES-1:0] mode_onehot;
    logic [IDX_W-1:0]     mode_idx;
    logic                 mode_changed;
    logic                 wrapped;

    modport master (
        output btn_next_n, btn_prev_n, lock,
        input  mode_onehot, mode_idx, mode_changed, wrapped
    );

    modport slave (
        input  btn_next_n, btn_prev_n, lock,
        output mode_onehot, mode_idx, mode_changed, wrapped
    );
endinterface

// File: rtl/mode_sequencer.sv
// mode_sequencer
//   Cycles through NUM_MODES modes using two debounced push buttons.
//   Each button goes through a 2-flop synchroniser and its own debouncer.
//   A falling edge of a debounced level is a press event. A next press
//   increments the mode and a prev press decrements it, both with wrap-around.
//   Next and prev presses in the same cycle cancel each other. lock discards
//   press events, but debouncing keeps running while it is high.
//
//   Optional feature: define MODE_SEQ_AUTOREPEAT_EN to enable auto-repeat.
//   While exactly one button stays pressed and lock is low, an extra event of
//   that direction fires every REPEAT_CYCLES cycles after the press event.
//   With the macro undefined, each press gives exactly one event.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    mode_sequencer_if.slave (buttons, lock, mode outputs)
module mode_sequencer #(
    parameter int NUM_MODES       = 4,
    parameter int IDX_W           = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mode_sequencer_if.slave  bus
);
    localparam int              DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MODES - 1);

    if (NUM_MODES < 2 || NUM_MODES > (1 << IDX_W) || DEBOUNCE_CYCLES < 1 ||
        REPEAT_CYCLES < 2) begin : g_bad_params
        $error("mode_sequencer: illegal parameter combination");
    end

    // Bit 0 is the next button and bit 1 is the prev button throughout.
    // All button levels are active-low (1 = released).
    logic [1:0]      raw_n;
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      deb_q, deb_d;
    logic [1:0]      deb_dly_q, deb_dly_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      press;
    logic [1:0]      rep_ev;
    logic [1:0]      ev;

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_MODES-1:0] onehot_q, onehot_d;
    logic                 changed_q, changed_d;
    logic                 wrapped_q, wrapped_d;

    assign raw_n = {bus.btn_prev_n, bus.btn_next_n};

    // The counter measures how long the synchronised level has disagreed with
    // the debounced level. The flip happens on the mismatch seen with the
    // counter at DEBOUNCE_CYCLES-1, and the counter returns to zero then.
    always_comb begin
        sync1_d   = raw_n;
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        for (int b = 0; b < 2; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] != deb_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) deb_d[b] = sync2_q[b];
                else                        db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
            end
        end
    end

    // A press is the one cycle where the debounced level is low and its
    // delayed copy is still high. Releases produce nothing.
    assign press = ~deb_q & deb_dly_q;

`ifdef MODE_SEQ_AUTOREPEAT_EN
    localparam int              RP_W    = $clog2(REPEAT_CYCLES);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [1:0]      held;

    // One counter serves both buttons, because at most one can be held
    // exclusively at a time. It clears on the press cycle itself, so the
    // first repeat lands exactly REPEAT_CYCLES cycles after the press event.
    always_comb begin
        held      = ~deb_q & {deb_q[0], deb_q[1]};
        rep_cnt_d = '0;
        rep_ev    = '0;
        if ((|held) && !bus.lock && !(|press)) begin
            if (rep_cnt_q == RP_LAST) rep_ev = held;
            else                      rep_cnt_d = rep_cnt_q + RP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_cnt_q <= '0;
        else        rep_cnt_q <= rep_cnt_d;
    end
`else
    assign rep_ev = 2'b00;
`endif

    always_comb begin
        ev        = (press | rep_ev) & {2{~bus.lock}};
        idx_d     = idx_q;
        changed_d = 1'b0;
        wrapped_d = 1'b0;
        if (ev == 2'b01) begin
            changed_d = 1'b1;
            if (idx_q == LAST_IDX) begin
                idx_d     = '0;
                wrapped_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (ev == 2'b10) begin
            changed_d = 1'b1;
            if (idx_q == '0) begin
                idx_d     = LAST_IDX;
                wrapped_d = 1'b1;
            end else begin
                idx_d = idx_q - IDX_W'(1);
            end
        end
        onehot_d        = '0;
        onehot_d[idx_d] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            deb_q     <= 2'b11;
            deb_dly_q <= 2'b11;
            db_cnt_q  <= '{default: '0};
            idx_q     <= '0;
            onehot_q  <= NUM_MODES'(1);
            changed_q <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            db_cnt_q  <= db_cnt_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
            changed_q <= changed_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign bus.mode_idx     = idx_q;
    assign bus.mode_onehot  = onehot_q;
    assign bus.mode_changed = changed_q;
    assign bus.wrapped      = wrapped_q;
endmodule
